// File: rtl/mem_pkg.sv
// Shared constants and types for the mem_responder memory model.
// Imported by the lane unit and the responder top.
package mem_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam int MEM_CNT_W = 4;

    typedef enum logic [1:0] {
        MEM_ST_IDLE    = 2'd0,
        MEM_ST_BUSY    = 2'd1,
        MEM_ST_DONE    = 2'd2,
        MEM_ST_RELEASE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane steering: merged write word, byte enables,
// and zero-extended read extraction for byte/half/word accesses.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wword_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        wword_o = word_i;
        be_o    = 4'b1111;
        rdata_o = word_i;
        case (size_i)
            MEM_SIZE_BYTE: begin
                be_o = 4'b0001 << offset_i;
                wword_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
                rdata_o = {24'b0, word_i[{offset_i, 3'b000} +: 8]};
            end
            MEM_SIZE_HALF: begin
                be_o = offset_i[1] ? 4'b1100 : 4'b0011;
                wword_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                rdata_o = {16'b0, word_i[{offset_i[1], 4'b0000} +: 16]};
            end
            // reserved size 11 behaves as a full word
            default: begin
                wword_o = wdata_i;
                rdata_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Simulation RAM target for the core's cs/we/oe memory interface.
// Fixed-latency access, one-cycle ram_ready pulse, cs must drop between accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 12,
    parameter int    LATENCY    = 3,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        oe,
    input  logic [31:0] address,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ram_ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [MEM_CNT_W-1:0] CNT_LOAD = MEM_CNT_W'(LATENCY - 1);

    logic [31:0] mem_q [DEPTH];

    mem_state_e             state_q, state_d;
    logic [MEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0]  addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   ready_q, ready_d;
    logic [31:0]            dout_q, dout_d;
    logic                   wr_en;

    logic [ADDR_WIDTH-1:0]  idx;
    logic [31:0]            wword;
    logic [3:0]             be;
    logic [31:0]            rdata;
    logic                   unused_hi;

    assign idx       = addr_q[ADDR_WIDTH+1:2];
    assign unused_hi = ^address[31:ADDR_WIDTH+2];

    mem_lane_unit u_lane (
        .word_i   (mem_q[idx]),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .wdata_i  (wdata_q),
        .wword_o  (wword),
        .be_o     (be),
        .rdata_o  (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            MEM_ST_IDLE: begin
                if (cs && (we ^ oe)) begin
                    addr_d  = address[ADDR_WIDTH+1:0];
                    size_d  = data_size;
                    wdata_d = data_in;
                    we_d    = we;
                    cnt_d   = CNT_LOAD;
                    state_d = MEM_ST_BUSY;
                end
            end
            MEM_ST_BUSY: begin
                if (!cs) begin
                    state_d = MEM_ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ready_d = 1'b1;
                    state_d = MEM_ST_DONE;
                    if (we_q) wr_en = 1'b1;
                    else      dout_d = rdata;
                end
            end
            MEM_ST_DONE: begin
                state_d = cs ? MEM_ST_RELEASE : MEM_ST_IDLE;
            end
            MEM_ST_RELEASE: begin
                if (!cs) state_d = MEM_ST_IDLE;
            end
            default: state_d = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= MEM_SIZE_WORD;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
        end
    end

    // array is never cleared; a reset on the completing edge drops the write
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign data_out  = dout_q;
    assign ram_ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY 3 main instance plus
// LATENCY 1 and 15 instances sharing the same request stream.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic        oe;
    logic [31:0] address;
    logic [1:0]  data_size;
    logic [31:0] data_in;

    logic [31:0] dout3, dout1, dout15;
    logic        rdy3, rdy1, rdy15;

    int cyc  = 0;
    int n3   = 0, n1 = 0, n15 = 0;
    int l3   = 0, l1 = 0, l15 = 0;
    int s3   = 0, s1 = 0, s15 = 0;
    int acc  = 0;
    int n_chk  = 0;
    int n_pass = 0;

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe),
        .address(address), .data_size(data_size), .data_in(data_in),
        .data_out(dout3), .ram_ready(rdy3)
    );

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe),
        .address(address), .data_size(data_size), .data_in(data_in),
        .data_out(dout1), .ram_ready(rdy1)
    );

    mem_responder #(.ADDR_WIDTH(12), .LATENCY(15)) u_dut15 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe),
        .address(address), .data_size(data_size), .data_in(data_in),
        .data_out(dout15), .ram_ready(rdy15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy3 === 1'b1)  begin n3++;  l3  = cyc; end
        if (rdy1 === 1'b1)  begin n1++;  l1  = cyc; end
        if (rdy15 === 1'b1) begin n15++; l15 = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s3  = n3;
        s1  = n1;
        s15 = n15;
        acc = cyc + 1;
    endtask

    task automatic req(input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d,
                       input int hold);
        address   = a;
        data_size = sz;
        data_in   = d;
        we        = w;
        oe        = !w;
        cs        = 1'b1;
        snap();
        tick(hold);
        cs = 1'b0;
        we = 1'b0;
        oe = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; oe = 1'b1; we = 1'b0;
        address = 32'h0; data_size = 2'b10; data_in = 32'h0;

        tick(1);
        @(negedge clk);
        chk("rst_rdy_0", 32'(rdy3), 32'h0);
        chk("rst_dout_0", dout3, 32'h0);
        tick(1);
        @(negedge clk);
        chk("rst_rdy_1", 32'(rdy3), 32'h0);
        chk("rst_dout_1", dout3, 32'h0);
        rst = 1'b0; cs = 1'b0; oe = 1'b0;
        tick(1);

        req(1'b1, 32'h0, 2'b10, 32'hDEADBEEF, 6);
        chk("w0_pulses", 32'(n3 - s3), 32'd1);
        chk("w0_lat", 32'(l3 - acc), 32'd3);
        req(1'b0, 32'h0, 2'b10, 32'h0, 6);
        chk("r0_data", dout3, 32'hDEADBEEF);
        chk("r0_lat", 32'(l3 - acc), 32'd3);

        req(1'b1, 32'h40, 2'b10, 32'h11223344, 6);
        chk("wr_keeps_dout", dout3, 32'hDEADBEEF);
        req(1'b1, 32'h41, 2'b00, 32'hFFFFFFAA, 6);
        req(1'b1, 32'h42, 2'b01, 32'h1234BEEF, 6);
        req(1'b0, 32'h40, 2'b10, 32'h0, 6);
        chk("merge_word", dout3, 32'hBEEFAA44);
        req(1'b0, 32'h43, 2'b00, 32'h0, 6);
        chk("byte_rd_43", dout3, 32'h000000BE);
        req(1'b0, 32'h40, 2'b01, 32'h0, 6);
        chk("half_rd_40", dout3, 32'h0000AA44);
        req(1'b0, 32'h42, 2'b00, 32'h0, 6);
        chk("byte_rd_42", dout3, 32'h000000EF);
        req(1'b0, 32'h43, 2'b01, 32'h0, 6);
        chk("half_rd_43", dout3, 32'h0000BEEF);
        req(1'b0, 32'h41, 2'b11, 32'h0, 6);
        chk("size11_word", dout3, 32'hBEEFAA44);

        req(1'b0, 32'h40, 2'b00, 32'h0, 10);
        chk("held_one_pulse", 32'(n3 - s3), 32'd1);
        chk("held_data", dout3, 32'h00000044);
        req(1'b0, 32'h40, 2'b10, 32'h0, 6);
        chk("rearm_pulse", 32'(n3 - s3), 32'd1);
        chk("rearm_lat", 32'(l3 - acc), 32'd3);

        req(1'b1, 32'h80, 2'b10, 32'hCAFEF00D, 6);
        req(1'b1, 32'h80, 2'b00, 32'h00000055, 2);
        chk("abort_no_pulse", 32'(n3 - s3), 32'd0);
        req(1'b0, 32'h80, 2'b10, 32'h0, 6);
        chk("abort_old_val", dout3, 32'hCAFEF00D);

        address = 32'h80; data_size = 2'b00; data_in = 32'h55;
        we = 1'b1; oe = 1'b0; cs = 1'b1;
        snap();
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; cs = 1'b0; we = 1'b0;
        tick(1);
        chk("rst_mid_no_pulse", 32'(n3 - s3), 32'd0);
        chk("rst_mid_dout", dout3, 32'h0);
        req(1'b0, 32'h80, 2'b10, 32'h0, 6);
        chk("rst_mid_old_val", dout3, 32'hCAFEF00D);

        cs = 1'b1; we = 1'b1; oe = 1'b1;
        snap();
        tick(5);
        cs = 1'b0; we = 1'b0; oe = 1'b0;
        tick(1);
        chk("illegal_no_pulse", 32'(n3 - s3), 32'd0);

        req(1'b1, 32'h00004008, 2'b10, 32'h12345678, 6);
        req(1'b0, 32'h00000008, 2'b10, 32'h0, 6);
        chk("wrap_read", dout3, 32'h12345678);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        req(1'b1, 32'h100, 2'b10, 32'hA5A55A5A, 20);
        chk("sw_w_pulse1", 32'(n1 - s1), 32'd1);
        chk("sw_w_pulse15", 32'(n15 - s15), 32'd1);
        chk("sw_w_lat1", 32'(l1 - acc), 32'd1);
        chk("sw_w_lat15", 32'(l15 - acc), 32'd15);
        req(1'b0, 32'h100, 2'b10, 32'h0, 20);
        chk("sw_r_lat1", 32'(l1 - acc), 32'd1);
        chk("sw_r_lat15", 32'(l15 - acc), 32'd15);
        chk("sw_r_data1", dout1, 32'hA5A55A5A);
        chk("sw_r_data15", dout15, 32'hA5A55A5A);
        req(1'b1, 32'h100, 2'b10, 32'h0BADF00D, 20);
        chk("sw_hold1", dout1, 32'hA5A55A5A);
        chk("sw_hold15", dout15, 32'hA5A55A5A);
        req(1'b0, 32'h100, 2'b01, 32'h0, 20);
        chk("sw_next1", dout1, 32'h0000F00D);
        chk("sw_next15", dout15, 32'h0000F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
